// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequencer/arbiter for the single-port CSR file.
// Two requesters share the port: the CSR-instruction path (CSRRW/S/C
// read-modify-write) and the trap path (trap entry writes mepc/mcause and
// reads mtvec; mret reads mepc). One transaction is in flight at a time.
//
// Handshake: a requester raises valid with its payload and holds both until
// it sees ready high at a rising edge; that edge is the accept edge. ready is
// only ever high in IDLE, trap_ready is unconditional there and insn_ready is
// suppressed while trap_valid is high, so a trap always wins a tie. Payload
// is captured on the accept edge and the inputs are ignored afterwards.
//
// All FSM-driven outputs (CSR port, done pulses, returned data) are
// registered and computed for the state being entered. Every output is
// forced to 0 while rst_n is low, which also suppresses a CSR write that
// would otherwise land on the reset edge.

module csr_access_ctrl #(
    parameter int          WORD_LEN    = 32,
    parameter logic [11:0] ADDR_MEPC   = 12'h341,
    parameter logic [11:0] ADDR_MCAUSE = 12'h342,
    parameter logic [11:0] ADDR_MTVEC  = 12'h305
) (
    input  logic                clk,
    input  logic                rst_n,
    // CSR instruction port
    input  logic                insn_valid,
    output logic                insn_ready,
    input  logic [1:0]          insn_cmd,
    input  logic [11:0]         insn_addr,
    input  logic [WORD_LEN-1:0] insn_wdata,
    output logic [WORD_LEN-1:0] insn_rdata,
    output logic                insn_done,
    // trap port
    input  logic                trap_valid,
    input  logic                trap_kind,
    input  logic [WORD_LEN-1:0] trap_pc,
    input  logic [WORD_LEN-1:0] trap_cause,
    output logic                trap_ready,
    output logic                trap_done,
    output logic [WORD_LEN-1:0] trap_target,
    // CSR file port
    output logic [11:0]         csr_addr,
    output logic                csr_wen,
    output logic [WORD_LEN-1:0] csr_wdata,
    input  logic [WORD_LEN-1:0] csr_rdata,
    // status
    output logic                busy
);

    localparam logic [1:0] CMD_RO = 2'd0;
    localparam logic [1:0] CMD_W  = 2'd1;
    localparam logic [1:0] CMD_S  = 2'd2;
    localparam logic [1:0] CMD_C  = 2'd3;

    // mtvec is used in direct mode only: the low two mode bits are dropped.
    localparam logic [WORD_LEN-1:0] VEC_MASK = ~WORD_LEN'(3);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_I_RD    = 4'd1,
        S_I_WR    = 4'd2,
        S_I_DONE  = 4'd3,
        S_T_EPC   = 4'd4,
        S_T_CAUSE = 4'd5,
        S_T_VEC   = 4'd6,
        S_R_EPC   = 4'd7,
        S_T_DONE  = 4'd8
    } state_t;

    // state_q is the debug view of the sequencer for hierarchical probes.
    state_t              state_q;

    // captured instruction payload
    logic [1:0]          cmd_q;
    logic [11:0]         addr_q;
    logic [WORD_LEN-1:0] operand_q;
    // captured trap payload (the PC is held in csr_wdata_q for the mepc write)
    logic [WORD_LEN-1:0] cause_q;
    // old CSR value read during I_RD
    logic [WORD_LEN-1:0] old_q;

    // registered outputs
    logic [11:0]         csr_addr_q;
    logic                csr_wen_q;
    logic [WORD_LEN-1:0] csr_wdata_q;
    logic                insn_done_q;
    logic                trap_done_q;
    logic [WORD_LEN-1:0] insn_rdata_q;
    logic [WORD_LEN-1:0] trap_target_q;

    // read-modify-write result; evaluated during I_RD, where csr_rdata is
    // the old value of the captured address, and registered into I_WR
    logic [WORD_LEN-1:0] rmw_wdata;
    logic                rmw_wen;

    // Compute the write data/enable for the captured command from the old value.
    always_comb begin
        rmw_wdata = '0;
        rmw_wen   = 1'b0;
        case (cmd_q)
            CMD_W: begin
                rmw_wdata = operand_q;
                rmw_wen   = 1'b1;
            end
            CMD_S: begin
                rmw_wdata = csr_rdata | operand_q;
                rmw_wen   = |operand_q;
            end
            CMD_C: begin
                rmw_wdata = csr_rdata & ~operand_q;
                rmw_wen   = |operand_q;
            end
            default: begin
                rmw_wdata = '0;
                rmw_wen   = 1'b0;
            end
        endcase
    end

    // Sequencer: state, captured payload and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cmd_q         <= CMD_RO;
            addr_q        <= '0;
            operand_q     <= '0;
            cause_q       <= '0;
            old_q         <= '0;
            csr_addr_q    <= '0;
            csr_wen_q     <= 1'b0;
            csr_wdata_q   <= '0;
            insn_done_q   <= 1'b0;
            trap_done_q   <= 1'b0;
            insn_rdata_q  <= '0;
            trap_target_q <= '0;
        end else begin
            insn_done_q <= 1'b0;
            trap_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (trap_valid) begin
                        cause_q    <= trap_cause;
                        csr_addr_q <= ADDR_MEPC;
                        if (!trap_kind) begin
                            state_q     <= S_T_EPC;
                            csr_wen_q   <= 1'b1;
                            csr_wdata_q <= trap_pc;
                        end else begin
                            state_q     <= S_R_EPC;
                            csr_wen_q   <= 1'b0;
                            csr_wdata_q <= '0;
                        end
                    end else if (insn_valid) begin
                        cmd_q       <= insn_cmd;
                        addr_q      <= insn_addr;
                        operand_q   <= insn_wdata;
                        state_q     <= S_I_RD;
                        csr_addr_q  <= insn_addr;
                        csr_wen_q   <= 1'b0;
                        csr_wdata_q <= '0;
                    end
                end
                S_I_RD: begin
                    old_q       <= csr_rdata;
                    state_q     <= S_I_WR;
                    csr_addr_q  <= addr_q;
                    csr_wen_q   <= rmw_wen;
                    csr_wdata_q <= rmw_wdata;
                end
                S_I_WR: begin
                    state_q      <= S_I_DONE;
                    csr_addr_q   <= '0;
                    csr_wen_q    <= 1'b0;
                    csr_wdata_q  <= '0;
                    insn_done_q  <= 1'b1;
                    insn_rdata_q <= old_q;
                end
                S_I_DONE: begin
                    state_q <= S_IDLE;
                end
                S_T_EPC: begin
                    state_q     <= S_T_CAUSE;
                    csr_addr_q  <= ADDR_MCAUSE;
                    csr_wen_q   <= 1'b1;
                    csr_wdata_q <= cause_q;
                end
                S_T_CAUSE: begin
                    state_q     <= S_T_VEC;
                    csr_addr_q  <= ADDR_MTVEC;
                    csr_wen_q   <= 1'b0;
                    csr_wdata_q <= '0;
                end
                S_T_VEC: begin
                    state_q       <= S_T_DONE;
                    trap_target_q <= csr_rdata & VEC_MASK;
                    trap_done_q   <= 1'b1;
                    csr_addr_q    <= '0;
                    csr_wen_q     <= 1'b0;
                    csr_wdata_q   <= '0;
                end
                S_R_EPC: begin
                    state_q       <= S_T_DONE;
                    trap_target_q <= csr_rdata;
                    trap_done_q   <= 1'b1;
                    csr_addr_q    <= '0;
                    csr_wen_q     <= 1'b0;
                    csr_wdata_q   <= '0;
                end
                S_T_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    csr_addr_q  <= '0;
                    csr_wen_q   <= 1'b0;
                    csr_wdata_q <= '0;
                end
            endcase
        end
    end

    // Drive the ports; everything reads 0 while reset is held.
    always_comb begin
        busy        = rst_n && (state_q != S_IDLE);
        trap_ready  = rst_n && (state_q == S_IDLE);
        insn_ready  = rst_n && (state_q == S_IDLE) && !trap_valid;
        csr_addr    = rst_n ? csr_addr_q    : '0;
        csr_wen     = rst_n && csr_wen_q;
        csr_wdata   = rst_n ? csr_wdata_q   : '0;
        insn_done   = rst_n && insn_done_q;
        trap_done   = rst_n && trap_done_q;
        insn_rdata  = rst_n ? insn_rdata_q  : '0;
        trap_target = rst_n ? trap_target_q : '0;
    end

    // Done pulses are single-cycle.
    a_insn_done_pulse : assert property (@(posedge clk) disable iff (!rst_n)
        insn_done |=> !insn_done);
    a_trap_done_pulse : assert property (@(posedge clk) disable iff (!rst_n)
        trap_done |=> !trap_done);
    // Writes only come from the three write states.
    a_wen_state : assert property (@(posedge clk) disable iff (!rst_n)
        csr_wen |-> (state_q == S_I_WR || state_q == S_T_EPC || state_q == S_T_CAUSE));

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl. A behavioural CSR file (4096 words,
// combinational read, write on the clock edge) sits on the CSR port and logs
// every write as {addr, data}. Inputs are driven 1 time unit after the
// rising edge and outputs are observed 2 units after it.

module tb_csr_access_ctrl;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          insn_valid;
    logic          insn_ready;
    logic [1:0]    insn_cmd;
    logic [11:0]   insn_addr;
    logic [W-1:0]  insn_wdata;
    logic [W-1:0]  insn_rdata;
    logic          insn_done;
    logic          trap_valid;
    logic          trap_kind;
    logic [W-1:0]  trap_pc;
    logic [W-1:0]  trap_cause;
    logic          trap_ready;
    logic          trap_done;
    logic [W-1:0]  trap_target;
    logic [11:0]   csr_addr;
    logic          csr_wen;
    logic [W-1:0]  csr_wdata;
    logic [W-1:0]  csr_rdata;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // CSR file model and write log
    logic [W-1:0]    csr_mem [4096];
    logic            pre_we;
    logic [11:0]     pre_addr;
    logic [W-1:0]    pre_data;
    logic [11+W:0]   wr_q[$];
    logic [11+W:0]   exp_q[$];

    csr_access_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .insn_valid  (insn_valid),
        .insn_ready  (insn_ready),
        .insn_cmd    (insn_cmd),
        .insn_addr   (insn_addr),
        .insn_wdata  (insn_wdata),
        .insn_rdata  (insn_rdata),
        .insn_done   (insn_done),
        .trap_valid  (trap_valid),
        .trap_kind   (trap_kind),
        .trap_pc     (trap_pc),
        .trap_cause  (trap_cause),
        .trap_ready  (trap_ready),
        .trap_done   (trap_done),
        .trap_target (trap_target),
        .csr_addr    (csr_addr),
        .csr_wen     (csr_wen),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .busy        (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- CSR file model ----------------
    assign csr_rdata = csr_mem[csr_addr];

    always @(posedge clk) begin
        if (pre_we) begin
            csr_mem[pre_addr] <= pre_data;
        end else if (csr_wen) begin
            csr_mem[csr_addr] <= csr_wdata;
            wr_q.push_back({csr_addr, csr_wdata});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [11:0] a, input logic [W-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        step();
        pre_we   = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n      = 1'b0;
        insn_valid = 1'b1;
        insn_cmd   = 2'd1;
        insn_addr  = 12'h340;
        insn_wdata = 32'hFFFF_FFFF;
        trap_valid = 1'b1;
        trap_kind  = 1'b0;
        trap_pc    = 32'h1000;
        trap_cause = 32'd11;
        step();
        step();
        n_cmp++;
        if ({insn_ready, trap_ready, busy, csr_wen, insn_done, trap_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {insn_ready, trap_ready, busy, csr_wen, insn_done, trap_done});
        end
        n_cmp++;
        if ({csr_addr, csr_wdata, insn_rdata, trap_target} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr %h wdata %h rdata %h target %h, expected all 0",
                     csr_addr, csr_wdata, insn_rdata, trap_target);
        end
        insn_valid = 1'b0;
        trap_valid = 1'b0;
        rst_n      = 1'b1;
        #1;
        n_cmp++;
        if ({trap_ready, insn_ready, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_idle: ready/ready/busy got %b expected 110",
                     {trap_ready, insn_ready, busy});
        end
    endtask

    task automatic test_csr_insn(input int first, input int last);
        logic [11:0]  a;
        logic [W-1:0] pre;
        logic [1:0]   cmd;
        logic [W-1:0] op;
        logic         ew;
        logic [W-1:0] ed;
        int           base;
        for (int v = first; v <= last; v++) begin
            case (v)
                0:       begin a = 12'h340; pre = 32'hAAAA_0000; cmd = 2'd1; op = 32'h1234_5678; ew = 1'b1; ed = 32'h1234_5678; end
                1:       begin a = 12'h340; pre = 32'h0000_FF00; cmd = 2'd2; op = 32'h0000_00FF; ew = 1'b1; ed = 32'h0000_FFFF; end
                2:       begin a = 12'h340; pre = 32'h0000_FF00; cmd = 2'd3; op = 32'h0000_F000; ew = 1'b1; ed = 32'h0000_0F00; end
                3:       begin a = 12'h340; pre = 32'h0000_FF00; cmd = 2'd2; op = 32'h0000_0000; ew = 1'b0; ed = 32'h0000_FF00; end
                4:       begin a = 12'h340; pre = 32'h0000_FF00; cmd = 2'd3; op = 32'h0000_0000; ew = 1'b0; ed = 32'h0000_FF00; end
                default: begin a = 12'h7C0; pre = 32'h5A5A_5A5A; cmd = 2'd0; op = 32'hFFFF_FFFF; ew = 1'b0; ed = 32'h0000_0000; end
            endcase
            preset(a, pre);
            exp_q.delete();
            if (ew) exp_q.push_back({a, ed});
            base = wr_q.size();
            // cycle 0: request offered
            insn_valid = 1'b1;
            insn_cmd   = cmd;
            insn_addr  = a;
            insn_wdata = op;
            #1;
            n_cmp++;
            if ({insn_ready, busy} !== 2'b10) begin
                n_fail++;
                $display("FAIL insn%0d_accept: ready/busy got %b expected 10", v, {insn_ready, busy});
            end
            // cycle 1: I_RD; payload on the port is now garbage
            step();
            insn_valid = 1'b0;
            insn_cmd   = 2'd1;
            insn_addr  = 12'hFFF;
            insn_wdata = 32'hDEAD_BEEF;
            #1;
            n_cmp++;
            if ({busy, insn_ready, csr_wen, csr_addr} !== {1'b1, 1'b0, 1'b0, a}) begin
                n_fail++;
                $display("FAIL insn%0d_rd: busy/ready/wen/addr got %b/%b/%b/%h expected 1/0/0/%h",
                         v, busy, insn_ready, csr_wen, csr_addr, a);
            end
            // cycle 2: I_WR
            step();
            #1;
            n_cmp++;
            if ({csr_wen, csr_addr, csr_wdata} !== {ew, a, ed}) begin
                n_fail++;
                $display("FAIL insn%0d_wr: wen/addr/wdata got %b/%h/%h expected %b/%h/%h",
                         v, csr_wen, csr_addr, csr_wdata, ew, a, ed);
            end
            // cycle 3: I_DONE
            step();
            #1;
            n_cmp++;
            if ({insn_done, insn_rdata} !== {1'b1, pre}) begin
                n_fail++;
                $display("FAIL insn%0d_done: done/rdata got %b/%h expected 1/%h", v, insn_done, insn_rdata, pre);
            end
            n_cmp++;
            if ({csr_wen, csr_addr, csr_wdata} !== '0) begin
                n_fail++;
                $display("FAIL insn%0d_done_port: wen/addr/wdata got %b/%h/%h expected 0/000/0",
                         v, csr_wen, csr_addr, csr_wdata);
            end
            // cycle 4: back in IDLE, rdata held
            step();
            #1;
            n_cmp++;
            if ({insn_done, busy, insn_ready, insn_rdata} !== {1'b0, 1'b0, 1'b1, pre}) begin
                n_fail++;
                $display("FAIL insn%0d_idle: done/busy/ready/rdata got %b/%b/%b/%h expected 0/0/1/%h",
                         v, insn_done, busy, insn_ready, insn_rdata, pre);
            end
            // scoreboard: write log
            n_cmp++;
            if (wr_q.size() - base != exp_q.size()) begin
                n_fail++;
                $display("FAIL insn%0d_nwrites: got %0d expected %0d", v, wr_q.size() - base, exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                if (base + i < wr_q.size()) begin
                    n_cmp++;
                    if (wr_q[base + i] !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL insn%0d_write%0d: got %h expected %h", v, i, wr_q[base + i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_ecall();
        int base;
        preset(12'h305, 32'h0000_0103);
        preset(12'h341, 32'h0000_0000);
        exp_q.delete();
        exp_q.push_back({12'h341, 32'h0000_0080});
        exp_q.push_back({12'h342, 32'h0000_000B});
        base = wr_q.size();
        trap_valid = 1'b1;
        trap_kind  = 1'b0;
        trap_pc    = 32'h0000_0080;
        trap_cause = 32'd11;
        #1;
        n_cmp++;
        if ({trap_ready, insn_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL ecall_accept: trap/insn ready got %b expected 10", {trap_ready, insn_ready});
        end
        step();
        trap_valid = 1'b0;
        trap_kind  = 1'b1;
        trap_pc    = 32'hFFFF_FFFF;
        trap_cause = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if ({csr_wen, csr_addr, csr_wdata} !== {1'b1, 12'h341, 32'h0000_0080}) begin
            n_fail++;
            $display("FAIL ecall_mepc: wen/addr/wdata got %b/%h/%h expected 1/341/00000080", csr_wen, csr_addr, csr_wdata);
        end
        step();
        #1;
        n_cmp++;
        if ({csr_wen, csr_addr, csr_wdata} !== {1'b1, 12'h342, 32'h0000_000B}) begin
            n_fail++;
            $display("FAIL ecall_mcause: wen/addr/wdata got %b/%h/%h expected 1/342/0000000b", csr_wen, csr_addr, csr_wdata);
        end
        step();
        #1;
        n_cmp++;
        if ({csr_wen, csr_addr, trap_done} !== {1'b0, 12'h305, 1'b0}) begin
            n_fail++;
            $display("FAIL ecall_mtvec: wen/addr/done got %b/%h/%b expected 0/305/0", csr_wen, csr_addr, trap_done);
        end
        step();
        #1;
        n_cmp++;
        if ({trap_done, trap_target, csr_addr} !== {1'b1, 32'h0000_0100, 12'h000}) begin
            n_fail++;
            $display("FAIL ecall_done: done/target/addr got %b/%h/%h expected 1/00000100/000", trap_done, trap_target, csr_addr);
        end
        step();
        #1;
        n_cmp++;
        if ({trap_done, busy, trap_target} !== {1'b0, 1'b0, 32'h0000_0100}) begin
            n_fail++;
            $display("FAIL ecall_idle: done/busy/target got %b/%b/%h expected 0/0/00000100", trap_done, busy, trap_target);
        end
        n_cmp++;
        if (wr_q.size() - base != exp_q.size()) begin
            n_fail++;
            $display("FAIL ecall_nwrites: got %0d expected %0d", wr_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < wr_q.size()) begin
                n_cmp++;
                if (wr_q[base + i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL ecall_write%0d: got %h expected %h", i, wr_q[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_mret();
        int base;
        preset(12'h341, 32'h0000_0084);
        base = wr_q.size();
        trap_valid = 1'b1;
        trap_kind  = 1'b1;
        trap_pc    = 32'h0000_1234;
        trap_cause = 32'd0;
        #1;
        n_cmp++;
        if (trap_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mret_accept: trap_ready got %b expected 1", trap_ready);
        end
        step();
        trap_valid = 1'b0;
        trap_kind  = 1'b0;
        #1;
        n_cmp++;
        if ({busy, csr_wen, csr_addr} !== {1'b1, 1'b0, 12'h341}) begin
            n_fail++;
            $display("FAIL mret_rd: busy/wen/addr got %b/%b/%h expected 1/0/341", busy, csr_wen, csr_addr);
        end
        step();
        #1;
        n_cmp++;
        if ({trap_done, trap_target} !== {1'b1, 32'h0000_0084}) begin
            n_fail++;
            $display("FAIL mret_done: done/target got %b/%h expected 1/00000084", trap_done, trap_target);
        end
        step();
        #1;
        n_cmp++;
        if ({trap_done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL mret_idle: done/busy got %b expected 00", {trap_done, busy});
        end
        n_cmp++;
        if (wr_q.size() != base) begin
            n_fail++;
            $display("FAIL mret_nwrites: got %0d expected 0", wr_q.size() - base);
        end
    endtask

    task automatic test_arbitration();
        int           t_done = -1;
        int           i_acc  = -1;
        int           i_done = -1;
        int           bad    = 0;
        logic [W-1:0] rd     = '0;
        logic [W-1:0] tt     = '0;
        preset(12'h340, 32'h1111_0000);
        preset(12'h305, 32'h0000_0202);
        insn_valid = 1'b1;
        insn_cmd   = 2'd1;
        insn_addr  = 12'h340;
        insn_wdata = 32'hCAFE_0000;
        trap_valid = 1'b1;
        trap_kind  = 1'b0;
        trap_pc    = 32'h0000_0040;
        trap_cause = 32'd2;
        #1;
        n_cmp++;
        if ({trap_ready, insn_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL arb_tie: trap/insn ready got %b expected 10", {trap_ready, insn_ready});
        end
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (trap_done && t_done < 0) begin
                t_done = cyc;
                tt     = trap_target;
            end
            if (insn_done && i_done < 0) begin
                i_done = cyc;
                rd     = insn_rdata;
                tt     = trap_target;
            end
            if (insn_ready && busy) bad++;
            if (insn_valid && insn_ready && i_acc < 0) i_acc = cyc;
            step();
            trap_valid = 1'b0;
            if (i_acc >= 0) insn_valid = 1'b0;
            #1;
        end
        n_cmp++;
        if (t_done != 4) begin
            n_fail++;
            $display("FAIL arb_trap_done_cycle: got %0d expected 4", t_done);
        end
        n_cmp++;
        if (i_acc != 5) begin
            n_fail++;
            $display("FAIL arb_insn_accept_cycle: got %0d expected 5", i_acc);
        end
        n_cmp++;
        if (i_done != 8) begin
            n_fail++;
            $display("FAIL arb_insn_done_cycle: got %0d expected 8", i_done);
        end
        n_cmp++;
        if ({rd, tt} !== {32'h1111_0000, 32'h0000_0200}) begin
            n_fail++;
            $display("FAIL arb_data: rdata/target got %h/%h expected 11110000/00000200", rd, tt);
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL arb_ready_while_busy: got %0d cycles expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int           acc [2];
        int           dn  [2];
        logic [W-1:0] rd  [2];
        int           na = 0;
        int           nd = 0;
        acc[0] = -1; acc[1] = -1;
        dn[0]  = -1; dn[1]  = -1;
        rd[0]  = '0; rd[1]  = '0;
        preset(12'h340, 32'h0000_0001);
        insn_valid = 1'b1;
        insn_cmd   = 2'd2;
        insn_addr  = 12'h340;
        insn_wdata = 32'h0000_0010;
        #1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (insn_valid && insn_ready && na < 2) begin
                acc[na] = cyc;
                na++;
            end
            if (insn_done && nd < 2) begin
                dn[nd] = cyc;
                rd[nd] = insn_rdata;
                nd++;
            end
            step();
            if (na == 2) insn_valid = 1'b0;
            #1;
        end
        n_cmp++;
        if (acc[0] != 0 || acc[1] != 4) begin
            n_fail++;
            $display("FAIL b2b_accepts: got %0d,%0d expected 0,4", acc[0], acc[1]);
        end
        n_cmp++;
        if (dn[0] != 3 || dn[1] != 7) begin
            n_fail++;
            $display("FAIL b2b_dones: got %0d,%0d expected 3,7", dn[0], dn[1]);
        end
        n_cmp++;
        if ({rd[0], rd[1]} !== {32'h0000_0001, 32'h0000_0011}) begin
            n_fail++;
            $display("FAIL b2b_rdata: got %h,%h expected 00000001,00000011", rd[0], rd[1]);
        end
        n_cmp++;
        if (csr_mem[12'h340] !== 32'h0000_0011) begin
            n_fail++;
            $display("FAIL b2b_final: mscratch got %h expected 00000011", csr_mem[12'h340]);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        preset(12'h341, 32'h0000_0000);
        preset(12'h342, 32'h0000_0055);
        preset(12'h305, 32'h0000_0300);
        trap_valid = 1'b1;
        trap_kind  = 1'b0;
        trap_pc    = 32'h0000_0090;
        trap_cause = 32'd7;
        step();                // cycle 1: T_EPC
        trap_valid = 1'b0;
        step();                // cycle 2: T_CAUSE
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({csr_wen, busy, trap_ready, trap_done, csr_addr} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_in_reset: wen/busy/ready/done/addr got %b/%b/%b/%b/%h expected all 0",
                     csr_wen, busy, trap_ready, trap_done, csr_addr);
        end
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({busy, trap_ready, trap_done, csr_wen} !== 4'b0100) begin
            n_fail++;
            $display("FAIL rstmid_idle: busy/ready/done/wen got %b expected 0100", {busy, trap_ready, trap_done, csr_wen});
        end
        n_cmp++;
        if ({trap_target, insn_rdata} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_cleared: target/rdata got %h/%h expected 0/0", trap_target, insn_rdata);
        end
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (trap_done || csr_wen || busy) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad);
        end
        n_cmp++;
        if ({csr_mem[12'h341], csr_mem[12'h342]} !== {32'h0000_0090, 32'h0000_0055}) begin
            n_fail++;
            $display("FAIL rstmid_csrs: mepc/mcause got %h/%h expected 00000090/00000055",
                     csr_mem[12'h341], csr_mem[12'h342]);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        pre_we     = 1'b0;
        pre_addr   = '0;
        pre_data   = '0;
        rst_n      = 1'b0;
        insn_valid = 1'b0;
        insn_cmd   = 2'd0;
        insn_addr  = '0;
        insn_wdata = '0;
        trap_valid = 1'b0;
        trap_kind  = 1'b0;
        trap_pc    = '0;
        trap_cause = '0;
        test_reset();
        test_csr_insn(0, 5);
        test_ecall();
        test_mret();
        test_arbitration();
        test_back_to_back();
        test_reset_mid();
        test_csr_insn(0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_access_ctrl.md
# csr_access_ctrl

Sequencer and arbiter for the single-port CSR file (`Csr`). It shares that port between two requesters:
- the pipeline's CSR-instruction port (CSRRW/CSRRS/CSRRC);
- the trap port (ecall/exception entry and mret return).

Each access is a multi-cycle read-modify-write sequence. The block drives `csr_addr`, `csr_wen` and `csr_wdata`, and samples `csr_rdata`. It also returns the trap target PC.

## Interface
Parameters:
- `WORD_LEN`, 32, data width.
- `ADDR_MEPC`, 12'h341, machine exception PC.
- `ADDR_MCAUSE`, 12'h342, machine cause.
- `ADDR_MTVEC`, 12'h305, trap vector.

Ports (one clock, `clk`; reset `rst_n` is synchronous and active-low):
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `insn_valid`  in  1  CSR instruction request.
- `insn_ready`  out  1  request accepted this cycle.
- `insn_cmd`  in  2  0=read-only, 1=W, 2=S, 3=C.
- `insn_addr`  in  12  CSR address.
- `insn_wdata`  in  WORD_LEN  operand (rs1/uimm).
- `insn_rdata`  out  WORD_LEN  old CSR value, valid with `insn_done`.
- `insn_done`  out  1  one-cycle completion pulse.
- `trap_valid`  in  1  trap request.
- `trap_kind`  in  1  0=enter trap, 1=mret.
- `trap_pc`  in  WORD_LEN  faulting PC.
- `trap_cause`  in  WORD_LEN  cause code (11 = M-mode ecall).
- `trap_ready`  out  1  trap accepted this cycle.
- `trap_done`  out  1  one-cycle completion pulse.
- `trap_target`  out  WORD_LEN  next PC (mtvec or mepc), valid with `trap_done`.
- `csr_addr`  out  12  to CSR file.
- `csr_wen`  out  1  CSR write enable.
- `csr_wdata`  out  WORD_LEN  CSR write data.
- `csr_rdata`  in  WORD_LEN  combinational read data of `csr_addr`.
- `busy`  out  1  state != IDLE.

## Operation
**States:** IDLE, I_RD, I_WR, I_DONE, T_EPC, T_CAUSE, T_VEC, R_EPC, T_DONE.

**IDLE:**
- `trap_ready` = 1.
- `insn_ready` = !`trap_valid`.
- Trap wins when both requests are valid.
- On accept, the command, address, operands, PC and cause are captured into internal registers. Inputs are ignored after that point.

**Instruction path:**
- I_RD: `csr_addr` = captured address; `csr_rdata` is latched into `old`.
- I_WR: `csr_addr` = captured address. `csr_wdata` depends on the command:
  - W: operand.
  - S: `old` | operand.
  - C: `old` & ~operand.
  - read-only: 0.
- `csr_wen` is asserted in I_WR except in two cases:
  - the command is read-only;
  - the command is S or C and the operand is 0.
- I_DONE: `insn_done` = 1 and `insn_rdata` = `old`; the next state is IDLE.

**Trap entry (`trap_kind`=0):**
- T_EPC: writes mepc ← captured PC.
- T_CAUSE: writes mcause ← captured cause.
- T_VEC: reads mtvec; `trap_target` ← `csr_rdata` & ~3 (direct mode only).
- T_DONE: `trap_done` = 1; the next state is IDLE.

**mret (`trap_kind`=1):**
- R_EPC: reads mepc; `trap_target` ← `csr_rdata`.
- Then T_DONE.

**Outputs outside the states above:**
- `csr_addr` = 0 in IDLE and the DONE states.
- `csr_wen` = 0 in IDLE and the DONE states.
- `csr_wdata` = 0 in IDLE and the DONE states.

**Handshake:**
- Requesters hold `valid` and their payload until `ready`.
- Only one transaction is in flight at a time.
- Both ready signals are 0 outside IDLE.

## Timing
**Reset:**
- While `rst_n`=0 at a rising edge: state → IDLE.
- Also cleared: `old`, `insn_rdata`, `trap_target` and all captured registers.
- While `rst_n`=0, all outputs are 0, including both ready signals and `busy`.
- A reset in the middle of an operation aborts it:
  - no further `csr_wen`;
  - no done pulse;
  - any writes already issued remain in the CSR file.

**Latency, counting the accept cycle as cycle 0:**
- Instruction: I_RD at cycle 1, I_WR at cycle 2, `insn_done` at cycle 3.
- Trap entry: mepc write at cycle 1, mcause write at cycle 2, mtvec read at cycle 3, `trap_done` at cycle 4.
- mret: mepc read at cycle 1, `trap_done` at cycle 2.

**Back-to-back:**
- A new request can be accepted in the cycle after a DONE state, because IDLE is re-entered then.
- Minimum spacing between accepts: 4 cycles (instruction), 5 cycles (trap entry), 3 cycles (mret).

**Outputs and widths:**
- Done pulses are exactly 1 cycle wide.
- `insn_rdata` and `trap_target` are registered and hold their value until the next completion of the same kind.
- All arithmetic is bitwise on WORD_LEN bits; there is no overflow case.

## Test plan
- **CSRRW:** mscratch(0x340)=0xAAAA0000; CSRRW addr 0x340, wdata 0x12345678.
  - Expect `csr_wen` at cycle 2 with wdata 0x12345678.
  - Expect `insn_done` at cycle 3 with `insn_rdata`=0xAAAA0000.
- **CSRRS/CSRRC:** on 0x340=0x0000FF00.
  - S 0x000000FF → write 0x0000FFFF.
  - C 0x0000F000 → write 0x00000F00.
  - S with operand 0 → `csr_wen` never asserted; `insn_rdata`=0x0000FF00.
- **ecall:** mtvec=0x00000103; trap_kind=0, pc=0x80, cause=11.
  - Expect mepc=0x80 written at cycle 1 and mcause=11 at cycle 2.
  - Expect `trap_done` at cycle 4 with `trap_target`=0x100.
- **mret:** mepc=0x84 → `trap_done` at cycle 2, `trap_target`=0x84.
- **Arbitration:** `insn_valid` and `trap_valid` rise in the same cycle.
  - Expect `trap_ready`=1 and `insn_ready`=0.
  - The instruction is accepted in the cycle after `trap_done`.
  - Its completion pulse follows 3 cycles later.
- **Reset mid-operation:** drop `rst_n` during T_CAUSE.
  - Expect the next cycle to show IDLE outputs all 0, with no `trap_done`.
  - mepc keeps the value written at cycle 1.
  - After release, a fresh CSRRW completes normally.
